// File: rtl/traffic_conflict_monitor.sv
// Receive-side safety checker for the intersection lamp bus. It debounces both heads and
// latches any rule violation as a fault. Define TLM_WATCHDOG_EN to build the stuck-head watchdog.
//   state | meaning
//   IDLE  | flash/off mode, checks disarmed
//   MON   | normal sequence being monitored
//   FAULT | violation latched, waiting for a clean clear
module traffic_conflict_monitor #(
  parameter int PERSIST_CYC = 4,
  parameter int MIN_YEL_CYC = 8,
  parameter int WDOG_CYC    = 1024,
  parameter int CNT_W       = 32
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       enable,
  input  logic       clear,
  input  logic [4:0] set1,
  input  logic [4:0] set2,
  output logic       fault,
  output logic [4:0] fault_vec,
  output logic       active
);
  typedef enum logic [1:0] {IDLE = 2'd0, MON = 2'd1, FAULT = 2'd2} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] PERSIST = CNT_W'(PERSIST_CYC);
  localparam logic [CNT_W-1:0] MIN_YEL = CNT_W'(MIN_YEL_CYC);
  localparam logic [2:0] T_RED = 3'b100;
  localparam logic [2:0] T_YEL = 3'b010;
  localparam logic [2:0] T_GRN = 3'b001;

  state_t state, state_nx;
  logic                  fault_nx;
  logic [4:0]            vec_nx;
  logic [1:0][4:0]       set_h, samp, stab;
  logic [1:0][2:0]       prev_t;
  logic [1:0][CNT_W-1:0] run, yel;
  logic [1:0]            valid, load, go, red_only, lamp_ok, ped_bad, walk, trans_bad;
  logic                  chk_on, chk_wd, idle_entry, fault_clr;
  logic [4:0]            chk;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  assign set_h[0] = set1;
  assign set_h[1] = set2;

  // Head 1 pedestrians cross head 2 traffic and vice versa.
  always_comb begin
    for (int h = 0; h < 2; h++) begin
      load[h]      = (run[h] == PERSIST);
      go[h]        = stab[h][3] | stab[h][2];
      red_only[h]  = (stab[h][4:2] == T_RED);
      lamp_ok[h]   = (stab[h][4:2] == T_RED) || (stab[h][4:2] == T_YEL) || (stab[h][4:2] == T_GRN);
      ped_bad[h]   = (stab[h][1:0] == 2'b11);
      walk[h]      = stab[h][0];
      trans_bad[h] = red_only[h] &&
                     (((prev_t[h] == T_YEL) && (yel[h] < MIN_YEL)) || (prev_t[h] == T_GRN));
    end
  end

  assign chk_on = (state != IDLE) && valid[0] && valid[1];
  assign chk    = chk_on ? {chk_wd,
                            |trans_bad,
                            (walk[0] & ~red_only[1]) | (walk[1] & ~red_only[0]),
                            (~&lamp_ok) | (|ped_bad),
                            &go}
                         : 5'b00000;

  always_comb begin
    state_nx = state;
    fault_nx = fault;
    vec_nx   = fault_vec;
    case (state)
      IDLE: if (enable) state_nx = MON;
      MON: begin
        if (|chk) begin
          state_nx = FAULT;
          fault_nx = 1'b1;
          vec_nx   = fault_vec | chk;
        end else if (!enable) begin
          state_nx = IDLE;
        end
      end
      FAULT: begin
        vec_nx = fault_vec | chk;
        if (clear && !(|chk)) begin
          state_nx = MON;
          fault_nx = 1'b0;
          vec_nx   = 5'b00000;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign idle_entry = (state == MON) && (state_nx == IDLE);
  assign fault_clr  = (state == FAULT) && (state_nx == MON);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state     <= IDLE;
      fault     <= 1'b0;
      fault_vec <= 5'b00000;
      active    <= 1'b0;
    end else begin
      state     <= state_nx;
      fault     <= fault_nx;
      fault_vec <= vec_nx;
      active    <= (state == MON) && valid[0] && valid[1];
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      samp   <= '0;
      stab   <= '0;
      run    <= '0;
      yel    <= '0;
      prev_t <= '0;
      valid  <= '0;
    end else begin
      for (int h = 0; h < 2; h++) begin
        samp[h] <= set_h[h];
        if (idle_entry) begin
          run[h]    <= '0;
          yel[h]    <= '0;
          prev_t[h] <= 3'b000;
          valid[h]  <= 1'b0;
        end else begin
          run[h] <= (set_h[h] == samp[h]) ? sat_inc(run[h]) : CNT_W'(1);
          if (load[h]) begin
            stab[h]  <= samp[h];
            valid[h] <= 1'b1;
          end
          // A cleared history cannot fake a yellow/green to red transition.
          prev_t[h] <= valid[h] ? stab[h][4:2] : 3'b000;
          if (fault_clr || !valid[h] || (stab[h][4:2] != T_YEL)) yel[h] <= '0;
          else yel[h] <= sat_inc(yel[h]);
        end
      end
    end
  end

`ifdef TLM_WATCHDOG_EN
  localparam logic [CNT_W-1:0] WDOG = CNT_W'(WDOG_CYC);
  logic [1:0][CNT_W-1:0] wd;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      wd <= '0;
    end else begin
      for (int h = 0; h < 2; h++) begin
        if (idle_entry || !valid[h] || (load[h] && (samp[h] != stab[h]))) wd[h] <= '0;
        else wd[h] <= sat_inc(wd[h]);
      end
    end
  end

  assign chk_wd = (wd[0] >= WDOG) || (wd[1] >= WDOG);
`else
  logic unused_wdog;
  assign unused_wdog = WDOG_CYC[0];
  assign chk_wd      = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Self-checking bench for traffic_conflict_monitor: steady-vector table with a scoreboard
// queue, plus hand-written multi-cycle sequences (debounce, yellow timing, clear, enable, watchdog).
module tb_traffic_conflict_monitor;
  localparam logic [4:0] R_DW = 5'b10010;
  localparam logic [4:0] R_W  = 5'b10001;
  localparam logic [4:0] Y_DW = 5'b01010;
  localparam logic [4:0] G_DW = 5'b00110;
  localparam logic [4:0] G_W  = 5'b00101;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       enable = 1'b0;
  logic       clear = 1'b0;
  logic [4:0] set1 = 5'b0;
  logic [4:0] set2 = 5'b0;
  logic       fault;
  logic [4:0] fault_vec;
  logic       active;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [4:0] s1;
    logic [4:0] s2;
    logic       f;
    logic [4:0] v;
  } vec_t;

  vec_t tbl [11];
  vec_t exp_q [$];
  vec_t e;
  logic [4:0] ph_s1 [4];
  logic [4:0] ph_s2 [4];
  int         ph_len [4];
  int         edge_n;
  int         ylens [3];

  traffic_conflict_monitor #(
    .PERSIST_CYC(4),
    .MIN_YEL_CYC(8),
    .WDOG_CYC   (64),
    .CNT_W      (32)
  ) dut (
    .clock    (clock),
    .resetn   (resetn),
    .enable   (enable),
    .clear    (clear),
    .set1     (set1),
    .set2     (set2),
    .fault    (fault),
    .fault_vec(fault_vec),
    .active   (active)
  );

  always #5 clock = ~clock;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Leaves the bench just before edge 1 of a fresh run with the given steady inputs.
  task automatic restart(input logic [4:0] s1, input logic [4:0] s2, input logic en);
    resetn = 1'b0;
    enable = 1'b0;
    clear  = 1'b0;
    set1   = 5'b0;
    set2   = 5'b0;
    tick(2);
    resetn = 1'b1;
    set1   = s1;
    set2   = s2;
    enable = en;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: actual=running required=finished");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{R_DW,     G_W,      1'b0, 5'b00000};
    tbl[1]  = '{G_DW,     G_DW,     1'b1, 5'b00001};
    tbl[2]  = '{Y_DW,     G_DW,     1'b1, 5'b00001};
    tbl[3]  = '{5'b00010, R_DW,     1'b1, 5'b00010};
    tbl[4]  = '{5'b11010, R_DW,     1'b1, 5'b00010};
    tbl[5]  = '{5'b10011, R_DW,     1'b1, 5'b00010};
    tbl[6]  = '{R_W,      G_DW,     1'b1, 5'b00100};
    tbl[7]  = '{Y_DW,     R_W,      1'b1, 5'b00100};
    tbl[8]  = '{R_W,      R_W,      1'b0, 5'b00000};
    tbl[9]  = '{5'b00111, G_DW,     1'b1, 5'b00111};
    tbl[10] = '{5'b11111, 5'b11111, 1'b1, 5'b00111};
    ph_s1  = '{R_DW, R_DW, G_W, Y_DW};
    ph_s2  = '{G_W, Y_DW, R_DW, R_DW};
    ph_len = '{20, 10, 20, 10};
    ylens  = '{5, 7, 8};

    // Reset state
    resetn = 1'b0;
    tick(2);
    check("reset_fault", fault, 0);
    check("reset_vec", fault_vec, 0);
    check("reset_active", active, 0);

    // Steady vectors: fault must appear at edge 6, not edge 5
    for (int i = 0; i < 11; i++) begin
      restart(tbl[i].s1, tbl[i].s2, 1'b1);
      exp_q.push_back(tbl[i]);
      tick(5);
      check($sformatf("tbl%0d_edge5_fault", i), fault, 0);
      tick(1);
      e = exp_q.pop_front();
      check($sformatf("tbl%0d_fault", i), fault, e.f);
      check($sformatf("tbl%0d_vec", i), fault_vec, e.v);
      if (!e.f) check($sformatf("tbl%0d_active", i), active, 1);
    end

    // Legal full cycle
    restart(R_DW, G_W, 1'b1);
    edge_n = 0;
    for (int p = 0; p < 4; p++) begin
      set1 = ph_s1[p];
      set2 = ph_s2[p];
      for (int c = 0; c < ph_len[p]; c++) begin
        tick(1);
        edge_n++;
        check($sformatf("legal_e%0d_fault", edge_n), fault, 0);
        if (edge_n >= 6) check($sformatf("legal_e%0d_active", edge_n), active, 1);
      end
    end
    enable = 1'b0;
    tick(2);
    check("disable_active", active, 0);
    check("disable_fault", fault, 0);

    // Yellow duration: 5 and 7 are short, 8 is the minimum legal
    for (int k = 0; k < 3; k++) begin
      restart(R_DW, G_DW, 1'b1);
      tick(10);
      set2 = Y_DW;
      tick(ylens[k]);
      set2 = R_DW;
      tick(5);
      check($sformatf("yel%0d_pre_fault", ylens[k]), fault, 0);
      tick(1);
      check($sformatf("yel%0d_fault", ylens[k]), fault, (ylens[k] < 8) ? 1 : 0);
      check($sformatf("yel%0d_vec", ylens[k]), fault_vec, (ylens[k] < 8) ? 5'b01000 : 5'b00000);
    end

    // Skipped yellow
    restart(R_DW, G_DW, 1'b1);
    tick(10);
    set2 = R_DW;
    tick(5);
    check("skip_pre_fault", fault, 0);
    tick(1);
    check("skip_fault", fault, 1);
    check("skip_vec", fault_vec, 5'b01000);

    // Glitch filter: 3-cycle dual-go is absorbed
    restart(R_DW, G_DW, 1'b1);
    tick(10);
    set1 = G_DW;
    tick(3);
    set1 = R_DW;
    for (int c = 0; c < 15; c++) begin
      tick(1);
      check($sformatf("glitch3_c%0d_fault", c), fault, 0);
    end

    // 4-cycle dual-go persists long enough to be caught
    restart(R_DW, G_DW, 1'b1);
    tick(10);
    set1 = G_DW;
    tick(4);
    set1 = R_DW;
    tick(2);
    check("glitch4_fault", fault, 1);
    check("glitch4_vec", fault_vec, 5'b00001);

    // Clear handling
    restart(G_DW, G_DW, 1'b1);
    tick(6);
    check("clr_init_fault", fault, 1);
    check("clr_init_vec", fault_vec, 5'b00001);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check("clr_blocked_fault", fault, 1);
    tick(2);
    check("clr_blocked_fault_later", fault, 1);
    set1 = R_DW;
    tick(10);
    check("clr_accum_vec", fault_vec, 5'b01001);
    check("clr_accum_fault", fault, 1);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check("clr_done_fault", fault, 0);
    check("clr_done_vec", fault_vec, 5'b00000);
    tick(1);
    check("clr_mon_active", active, 1);
    tick(5);
    check("clr_after_fault", fault, 0);

    // Violation and enable drop in the same MON cycle
    restart(G_DW, G_DW, 1'b1);
    tick(5);
    enable = 1'b0;
    tick(1);
    check("en_drop_fault", fault, 1);
    tick(3);
    check("en_ignored_fault", fault, 1);

    // Reset from FAULT
    resetn = 1'b0;
    tick(1);
    check("rst_fault", fault, 0);
    check("rst_vec", fault_vec, 0);
    check("rst_active", active, 0);

    // Disabled: violation not monitored
    restart(G_DW, G_DW, 1'b0);
    tick(10);
    check("idle_fault", fault, 0);
    check("idle_active", active, 0);

    // Long legal hold
    restart(R_DW, G_DW, 1'b1);
    tick(75);
`ifdef TLM_WATCHDOG_EN
    check("wdog_fault", fault, 1);
    check("wdog_vec", fault_vec, 5'b10000);
`else
    check("wdog_fault", fault, 0);
    check("wdog_vec", fault_vec, 5'b00000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
